fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch front end for the single-cycle MIPS datapath.
- Fetches words from instruction memory over a req/ack handshake and buffers them in a small FIFO queue.
- Presents the head instruction and its 6-bit opCode to the control decoder.
- Consumes the decoder's branch/jump outputs plus the ALU zero flag to redirect the PC, flushing stale instructions.

Parameters:
- ADDR_W, 32, byte-address width of PC and imemAddr (fixed at 32 for jump-target math).
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction queue entries (power of two, ≥2).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- imemReq  output  1  fetch request
- imemAddr  output  ADDR_W  word-aligned fetch address
- imemAck  input  1  request completed this cycle; imemData valid
- imemData  input  32  fetched instruction
- instrValid  output  1  queue head valid
- instr  output  32  queue head instruction
- instrPc  output  ADDR_W  address of head instruction
- opCode  output  6  instr[31:26], to control decoder
- instrAccept  input  1  downstream consumes head this cycle
- branch  input  1  head is beq (from decoder)
- jump  input  1  head is j (from decoder)
- zero  input  1  ALU zero for head

Behaviour:
- Reset (async, active-high) values:
  - state=FETCH; reqPc=RESET_PC; queue empty (count=0).
  - imemReq=0 while reset is asserted; instrValid=0; instr=0; instrPc=0; opCode=0.
- Memory handshake:
  - imemAddr=reqPc at all times; imemReq=1 in FETCH when count<DEPTH, and always in DRAIN.
  - Once raised, imemReq and imemAddr hold stable until the imemAck cycle; the request is never withdrawn.
  - Ack in the same cycle as req is legal (zero wait); arbitrary wait states are legal.
  - One request outstanding at most.
- Push: on ack in FETCH, {imemData, reqPc} enters the queue tail; reqPc += 4.
  - The next request may issue the following cycle, giving a throughput of 1 word/cycle with zero-wait memory.
- Pop: instrValid && instrAccept removes the head. Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect, evaluated only on a pop cycle:
  - take = jump | (branch & zero).
  - pcPlus4 = instrPc+4.
  - branch target = pcPlus4 + (sign-extended instr[15:0] << 2), mod 2^32.
  - jump target = {pcPlus4[31:28], instr[25:0], 2'b00}; jump has priority if both are set.
  - On take, all queue entries are flushed, including any push arriving in the same cycle (the pushed data is discarded).
  - If a request is outstanding and not acked this cycle: next state DRAIN, pendPc=target.
  - Otherwise: reqPc=target, state FETCH.
  - instrValid=0 the cycle after a redirect.
- DRAIN:
  - imemReq held at the old reqPc.
  - On ack, the data is discarded, reqPc=pendPc, state returns to FETCH.
  - No push occurs while in DRAIN.
- instrValid/instrAccept/branch/jump/zero without instrValid are ignored.
- Queue full (count=DEPTH): imemReq=0 until a pop.
- Queue empty: instrValid=0; instr, instrPc and opCode hold their last values.
- reset mid-request or mid-DRAIN: immediate return to reset state; a late imemAck after reset release with imemReq=0 is ignored.

Optional Feature:
- FETCH_PERF_EN defined adds output flushCount [15:0], reset 0.
  - Increments by the number of instructions discarded per redirect: queue entries behind the head, plus the same-cycle ack word, plus the DRAIN word.
  - Saturates at 16'hFFFF.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory returning addr-tagged words, instrAccept=1 → imemAddr sequence 0,4,8,C; instrPc follows one stage behind; instrValid continuous after the first word.
- instrAccept=0, DEPTH=2 → exactly two acks accepted (PCs 0,4); imemReq=0 until instrAccept=1; then fetch resumes at 8.
- Head at 0x10 with instr=0x1000FFFE, branch=1, zero=1, accepted → queue flushed; next imemAddr=0x0C; next valid instrPc=0x0C.
- Same as previous but zero=0 → no flush; sequential 0x14, 0x18 continue.
- Jump at 0x40 with instr=0x08000100 while memory has a 3-cycle wait on a request for 0x48 → DRAIN holds imemAddr=0x48 until ack; that data is dropped; next imemAddr=0x400. With FETCH_PERF_EN, flushCount=2.
- Assert reset during DRAIN, then release → imemReq=0 during reset; first imemAddr=RESET_PC; the stale ack is ignored; instrValid=0 until the new fetch returns.

Source files
------------

// File: rtl/fetch_if.sv
// Handshake bundle between the fetch unit, instruction memory and the decode stage.
// master = fetch unit side, slave = memory/decoder side.
interface fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imemReq;
  logic [ADDR_W-1:0] imemAddr;
  logic              imemAck;
  logic [31:0]       imemData;
  logic              instrValid;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instrPc;
  logic [5:0]        opCode;
  logic              instrAccept;
  logic              branch;
  logic              jump;
  logic              zero;

  modport master (
    output imemReq, imemAddr, instrValid, instr, instrPc, opCode,
    input  imemAck, imemData, instrAccept, branch, jump, zero
  );

  modport slave (
    input  imemReq, imemAddr, instrValid, instr, instrPc, opCode,
    output imemAck, imemData, instrAccept, branch, jump, zero
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction fetch front end: req/ack memory fetch, small instruction queue, branch/jump redirect.
// Optional macro FETCH_PERF_EN adds the saturating flushCount output.
module fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 DEPTH    = 2
) (
  input  logic       clk,
  input  logic       reset,
  fetch_if.master    bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] flushCount
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    FETCH,
    DRAIN
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_reqPc;
  logic [ADDR_W-1:0] r_pendPc;
  logic [PTR_W-1:0]  r_rp;
  logic [PTR_W-1:0]  r_wp;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_instrPc;
  logic [31:0]       r_qData [DEPTH];
  logic [ADDR_W-1:0] r_qPc   [DEPTH];

  logic              w_req;
  logic              w_ack;
  logic              w_push;
  logic              w_valid;
  logic              w_pop;
  logic              w_take;
  logic [CNT_W-1:0]  w_remain;
  logic [PTR_W-1:0]  w_headIdx;
  logic [ADDR_W-1:0] w_pcPlus4;
  logic [ADDR_W-1:0] w_brOff;
  logic [ADDR_W-1:0] w_brTgt;
  logic [ADDR_W-1:0] w_jTgt;
  logic [ADDR_W-1:0] w_target;

  // Request is gated by reset so nothing is presented to memory while reset is held.
  assign w_req     = ~reset & ((r_state == DRAIN) | (r_count < CNT_W'(DEPTH)));
  assign w_ack     = w_req & bus.imemAck;
  assign w_push    = w_ack & (r_state == FETCH);
  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid & bus.instrAccept;
  assign w_take    = w_pop & (bus.jump | (bus.branch & bus.zero));
  assign w_remain  = r_count - CNT_W'(w_pop);
  assign w_headIdx = w_pop ? (r_rp + PTR_W'(1)) : r_rp;

  assign w_pcPlus4 = r_instrPc + ADDR_W'(4);
  assign w_brOff   = {{(ADDR_W-18){r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_brTgt   = w_pcPlus4 + w_brOff;
  assign w_jTgt    = {w_pcPlus4[ADDR_W-1:28], r_instr[25:0], 2'b00};
  assign w_target  = bus.jump ? w_jTgt : w_brTgt;

  assign bus.imemReq    = w_req;
  assign bus.imemAddr   = r_reqPc;
  assign bus.instrValid = w_valid;
  assign bus.instr      = r_instr;
  assign bus.instrPc    = r_instrPc;
  assign bus.opCode     = r_instr[31:26];

  // Queue storage carries no reset; occupancy is tracked by the control registers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_qData[r_wp] <= bus.imemData;
      r_qPc[r_wp]   <= r_reqPc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_reqPc   <= RESET_PC;
      r_pendPc  <= RESET_PC;
      r_rp      <= '0;
      r_wp      <= '0;
      r_count   <= '0;
      r_instr   <= '0;
      r_instrPc <= '0;
    end else begin
      if (w_take) begin
        r_rp    <= '0;
        r_wp    <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wp <= r_wp + PTR_W'(1);
        if (w_pop)  r_rp <= r_rp + PTR_W'(1);
        r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        // Head registers track the entry that will be at the front next cycle;
        // when the queue drains empty they keep the last instruction shown.
        if (w_remain != '0) begin
          r_instr   <= r_qData[w_headIdx];
          r_instrPc <= r_qPc[w_headIdx];
        end else if (w_push) begin
          r_instr   <= bus.imemData;
          r_instrPc <= r_reqPc;
        end
      end

      case (r_state)
        FETCH: begin
          if (w_take) begin
            if (w_req && !w_ack) begin
              r_state  <= DRAIN;
              r_pendPc <= w_target;
            end else begin
              r_reqPc <= w_target;
            end
          end else if (w_push) begin
            r_reqPc <= r_reqPc + ADDR_W'(4);
          end
        end
        DRAIN: begin
          if (w_ack) begin
            r_reqPc <= r_pendPc;
            r_state <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] r_flushCount;
  logic [16:0] w_flushSum;

  // Every entry behind the head plus the in-flight word (acked now or drained later) is lost.
  assign w_flushSum = {1'b0, r_flushCount} + 17'(r_count - CNT_W'(1)) + 17'(w_req);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flushCount <= '0;
    end else if (w_take) begin
      r_flushCount <= w_flushSum[16] ? 16'hFFFF : w_flushSum[15:0];
    end
  end

  assign flushCount = r_flushCount;
`endif

endmodule
